mac_accum_seq_ctrl: RTL and testbench

Sequencer between the MAC array psum stream and mac_psum_accumulator. Per job it loads one FP32 bias, then passes psum beats through while counting elements and groups. It generates the inter_end and accum_end markers the accumulator needs. Jobs are configured by a valid/ready config handshake from the layer controller.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_accum_tile_cnt.sv | 42 ++++
 rtl/mac_accum_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_mac_accum_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC-array types and constants for the psum accumulation path.
// Imported by the accumulator sequencer and its tile counter.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BIAS,
        STREAM,
        DONE
    } acc_seq_state_t;

    localparam int MAC_PSUM_W  = 32;
    localparam int MAC_VEC_MAX = 64;

endpackage

// File: rtl/mac_accum_tile_cnt.sv
// Nested element/group counters for one accumulation job.
// Flags mark the last element of a group and the final group of a job.
module mac_accum_tile_cnt
    import mac_pkg::*;
#(
    parameter int VEC_W = 7,
    parameter int GRP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [VEC_W-1:0] i_vec_last,
    input  logic [GRP_W-1:0] i_grp_last,
    output logic             o_last_elem,
    output logic             o_last_grp
);

    logic [VEC_W-1:0] r_elem_cnt;
    logic [GRP_W-1:0] r_grp_cnt;

    assign o_last_elem = (r_elem_cnt == i_vec_last);
    assign o_last_grp  = (r_grp_cnt == i_grp_last);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_elem_cnt <= '0;
            r_grp_cnt  <= '0;
        end else if (i_clear) begin
            r_elem_cnt <= '0;
            r_grp_cnt  <= '0;
        end else if (i_advance) begin
            if (o_last_elem) begin
                r_elem_cnt <= '0;
                r_grp_cnt  <= o_last_grp ? '0 : r_grp_cnt + GRP_W'(1);
            end else begin
                r_elem_cnt <= r_elem_cnt + VEC_W'(1);
            end
        end
    end

endmodule

// File: rtl/mac_accum_seq_ctrl.sv
// Sequencer feeding bias and psum beats with end markers to the accumulator.
// Optional MAC_ACCUM_SEQ_CTRL_PERF_EN adds a saturating stall counter.
module mac_accum_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_PSUM_W,
    parameter int VEC_W  = 7,
    parameter int GRP_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [VEC_W-1:0]  i_cfg_vec_len,
    input  logic [GRP_W-1:0]  i_cfg_num_grp,
    input  logic              i_cfg_bias_en,
    input  logic [DATA_W-1:0] i_cfg_bias_data,
    input  logic              i_mac_valid,
    output logic              o_mac_ready,
    input  logic [DATA_W-1:0] i_mac_data,
    output logic              o_bias_enable,
    output logic              o_bias_valid,
    input  logic              i_bias_ready,
    output logic [DATA_W-1:0] o_bias_data,
    output logic              o_psum_valid,
    input  logic              i_psum_ready,
    output logic [DATA_W-1:0] o_psum_data,
    output logic              o_inter_end,
    output logic              o_accum_end,
    output logic              o_busy,
`ifdef MAC_ACCUM_SEQ_CTRL_PERF_EN
    output logic              o_done,
    output logic [31:0]       o_stall_cnt
`else
    output logic              o_done
`endif
);

    acc_seq_state_t    r_state;
    logic              r_cfg_ready;
    logic              r_bias_enable;
    logic              r_bias_valid;
    logic [DATA_W-1:0] r_bias_data;
    logic              r_busy;
    logic              r_done;
    logic [VEC_W-1:0]  r_vec_last;
    logic [GRP_W-1:0]  r_grp_last;

    logic w_stream;
    logic w_cfg_fire;
    logic w_psum_fire;
    logic w_last_elem;
    logic w_last_grp;

    assign w_stream    = (r_state == STREAM);
    assign w_cfg_fire  = i_cfg_valid & r_cfg_ready;
    assign w_psum_fire = w_stream & i_mac_valid & i_psum_ready;

    assign o_cfg_ready   = r_cfg_ready;
    assign o_bias_enable = r_bias_enable;
    assign o_bias_valid  = r_bias_valid;
    assign o_bias_data   = r_bias_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    assign o_psum_valid = w_stream & i_mac_valid;
    assign o_mac_ready  = w_stream & i_psum_ready;
    assign o_psum_data  = i_mac_data;
    assign o_inter_end  = w_stream & w_last_elem;
    assign o_accum_end  = w_stream & w_last_grp;

    mac_accum_tile_cnt #(
        .VEC_W (VEC_W),
        .GRP_W (GRP_W)
    ) u_cnt (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_cfg_fire),
        .i_advance   (w_psum_fire),
        .i_vec_last  (r_vec_last),
        .i_grp_last  (r_grp_last),
        .o_last_elem (w_last_elem),
        .o_last_grp  (w_last_grp)
    );

    // Lengths are stored as last index so 0 maps to 64 elements / 1 group.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_cfg_ready   <= 1'b1;
            r_bias_enable <= 1'b0;
            r_bias_valid  <= 1'b0;
            r_bias_data   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_vec_last    <= '0;
            r_grp_last    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cfg_fire) begin
                        r_vec_last    <= (i_cfg_vec_len == '0)
                                       ? VEC_W'(MAC_VEC_MAX - 1)
                                       : i_cfg_vec_len - VEC_W'(1);
                        r_grp_last    <= (i_cfg_num_grp == '0)
                                       ? '0
                                       : i_cfg_num_grp - GRP_W'(1);
                        r_bias_enable <= i_cfg_bias_en;
                        r_bias_data   <= i_cfg_bias_data;
                        r_bias_valid  <= i_cfg_bias_en;
                        r_cfg_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= i_cfg_bias_en ? BIAS : STREAM;
                    end
                end
                BIAS: begin
                    if (i_bias_ready) begin
                        r_bias_valid <= 1'b0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_psum_fire && w_last_elem && w_last_grp) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAC_ACCUM_SEQ_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_cfg_fire) begin
            r_stall_cnt <= '0;
        end else if (w_stream && i_mac_valid && !i_psum_ready
                     && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_accum_seq_ctrl.sv
// Directed bench for mac_accum_seq_ctrl; markers checked against beat index.
// Build with MAC_ACCUM_SEQ_CTRL_PERF_EN to also check o_stall_cnt.
module tb_mac_accum_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [6:0]  i_cfg_vec_len;
    logic [7:0]  i_cfg_num_grp;
    logic        i_cfg_bias_en;
    logic [31:0] i_cfg_bias_data;
    logic        i_mac_valid;
    logic        o_mac_ready;
    logic [31:0] i_mac_data;
    logic        o_bias_enable;
    logic        o_bias_valid;
    logic        i_bias_ready;
    logic [31:0] o_bias_data;
    logic        o_psum_valid;
    logic        i_psum_ready;
    logic [31:0] o_psum_data;
    logic        o_inter_end;
    logic        o_accum_end;
    logic        o_busy;
    logic        o_done;
`ifdef MAC_ACCUM_SEQ_CTRL_PERF_EN
    logic [31:0] o_stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int stalls  = 0;

    always #5 i_clk = ~i_clk;

    mac_accum_seq_ctrl dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_cfg_valid     (i_cfg_valid),
        .o_cfg_ready     (o_cfg_ready),
        .i_cfg_vec_len   (i_cfg_vec_len),
        .i_cfg_num_grp   (i_cfg_num_grp),
        .i_cfg_bias_en   (i_cfg_bias_en),
        .i_cfg_bias_data (i_cfg_bias_data),
        .i_mac_valid     (i_mac_valid),
        .o_mac_ready     (o_mac_ready),
        .i_mac_data      (i_mac_data),
        .o_bias_enable   (o_bias_enable),
        .o_bias_valid    (o_bias_valid),
        .i_bias_ready    (i_bias_ready),
        .o_bias_data     (o_bias_data),
        .o_psum_valid    (o_psum_valid),
        .i_psum_ready    (i_psum_ready),
        .o_psum_data     (o_psum_data),
        .o_inter_end     (o_inter_end),
        .o_accum_end     (o_accum_end),
        .o_busy          (o_busy),
`ifdef MAC_ACCUM_SEQ_CTRL_PERF_EN
        .o_done          (o_done),
        .o_stall_cnt     (o_stall_cnt)
`else
        .o_done          (o_done)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one config; afterwards the DUT is in BIAS or STREAM.
    task automatic start_cfg(input logic [6:0] vl, input logic [7:0] ng,
                             input logic ben, input logic [31:0] bias);
        i_cfg_valid     = 1'b1;
        i_cfg_vec_len   = vl;
        i_cfg_num_grp   = ng;
        i_cfg_bias_en   = ben;
        i_cfg_bias_data = bias;
        #1;
        chk("cfg_ready_idle", {31'd0, o_cfg_ready}, 32'd1);
        step();
        i_cfg_valid = 1'b0;
        stalls      = 0;
        chk("cfg_ready_busy", {31'd0, o_cfg_ready}, 32'd0);
        chk("busy", {31'd0, o_busy}, 32'd1);
        chk("bias_enable", {31'd0, o_bias_enable}, {31'd0, ben});
        chk("bias_valid", {31'd0, o_bias_valid}, {31'd0, ben});
    endtask

    task automatic bias_phase(input int hold, input logic [31:0] bias);
        i_mac_valid  = 1'b1;
        i_psum_ready = 1'b1;
        for (int k = 0; k < hold; k++) begin
            chk("bias_hold_valid", {31'd0, o_bias_valid}, 32'd1);
            chk("bias_hold_data", o_bias_data, bias);
            chk("bias_hold_mac_rdy", {31'd0, o_mac_ready}, 32'd0);
            chk("bias_hold_psum_v", {31'd0, o_psum_valid}, 32'd0);
            step();
        end
        i_mac_valid  = 1'b0;
        i_bias_ready = 1'b1;
        #1;
        chk("bias_data", o_bias_data, bias);
        step();
        i_bias_ready = 1'b0;
        chk("bias_once", {31'd0, o_bias_valid}, 32'd0);
    endtask

    // Markers are derived from the fire index: element = b % vl, group = b / vl.
    task automatic stream(input int vl, input int ng, input bit rnd,
                          input int nbeats);
        int b   = 0;
        int cyc = 0;
        logic v;
        logic r;
        logic [31:0] d;
        while (b < nbeats && cyc < 4000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            d = $urandom;
            i_mac_valid  = v;
            i_psum_ready = r;
            i_mac_data   = d;
            #1;
            chk("psum_valid", {31'd0, o_psum_valid}, {31'd0, v});
            chk("mac_ready", {31'd0, o_mac_ready}, {31'd0, r});
            chk("psum_data", o_psum_data, d);
            if (v && r) begin
                chk("inter_end", {31'd0, o_inter_end},
                    {31'd0, (b % vl) == vl - 1});
                chk("accum_end", {31'd0, o_accum_end},
                    {31'd0, (b / vl) == ng - 1});
                b++;
            end else if (v) begin
                stalls++;
            end
            chk("no_early_done", {31'd0, o_done}, 32'd0);
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_mac_valid = 1'b0;
        if (b < nbeats) chk("stream_timeout", b, nbeats);
    endtask

    task automatic finish_job();
        i_mac_valid  = 1'b1;
        i_psum_ready = 1'b1;
        #1;
        chk("done_pulse", {31'd0, o_done}, 32'd1);
        chk("done_busy", {31'd0, o_busy}, 32'd1);
        chk("done_psum_gated", {31'd0, o_psum_valid}, 32'd0);
        chk("done_mac_gated", {31'd0, o_mac_ready}, 32'd0);
`ifdef MAC_ACCUM_SEQ_CTRL_PERF_EN
        chk("stall_cnt", o_stall_cnt, stalls);
`endif
        step();
        i_mac_valid = 1'b0;
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        chk("idle_ready", {31'd0, o_cfg_ready}, 32'd1);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        i_reset         = 1'b0;
        i_cfg_valid     = 1'b0;
        i_cfg_vec_len   = '0;
        i_cfg_num_grp   = '0;
        i_cfg_bias_en   = 1'b0;
        i_cfg_bias_data = '0;
        i_mac_valid     = 1'b0;
        i_mac_data      = '0;
        i_bias_ready    = 1'b0;
        i_psum_ready    = 1'b0;
        step();
        chk("rst_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_bias_valid", {31'd0, o_bias_valid}, 32'd0);
        chk("rst_bias_data", o_bias_data, 32'd0);
        i_reset = 1'b1;
        step();

        // 64x2 with bias, accumulator always ready
        start_cfg(7'd64, 8'd2, 1'b1, 32'h3F80_0000);
        bias_phase(0, 32'h3F80_0000);
        stream(64, 2, 1'b0, 128);
        finish_job();

        // 4x3 without bias
        start_cfg(7'd4, 8'd3, 1'b0, 32'hDEAD_BEEF);
        stream(4, 3, 1'b0, 12);
        finish_job();

        // zero lengths behave as 64x1
        start_cfg(7'd0, 8'd0, 1'b0, 32'h0);
        stream(64, 1, 1'b0, 64);
        finish_job();

        // random handshake toggling, 5x2
        start_cfg(7'd5, 8'd2, 1'b0, 32'h0);
        stream(5, 2, 1'b1, 10);
        finish_job();

        // bias back-pressured for 10 cycles, then vec_len=1 job
        start_cfg(7'd1, 8'd2, 1'b1, 32'hC0A0_0000);
        bias_phase(10, 32'hC0A0_0000);
        stream(1, 2, 1'b0, 2);
        finish_job();

        // async reset mid-job at beat 20 of 64x2
        start_cfg(7'd64, 8'd2, 1'b0, 32'h0);
        stream(64, 2, 1'b0, 20);
        i_mac_valid  = 1'b1;
        i_psum_ready = 1'b1;
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_psum_valid", {31'd0, o_psum_valid}, 32'd0);
        chk("arst_mac_ready", {31'd0, o_mac_ready}, 32'd0);
        chk("arst_inter", {31'd0, o_inter_end}, 32'd0);
        chk("arst_accum", {31'd0, o_accum_end}, 32'd0);
        chk("arst_done", {31'd0, o_done}, 32'd0);
        chk("arst_bias_en", {31'd0, o_bias_enable}, 32'd0);
        i_mac_valid = 1'b0;
        step();
        chk("arst_no_done", {31'd0, o_done}, 32'd0);
        i_reset = 1'b1;
        step();
        start_cfg(7'd3, 8'd1, 1'b0, 32'h0);
        stream(3, 1, 1'b0, 3);
        finish_job();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
